// File: rtl/product_accumulator.sv
// product_accumulator
// Sums groups of signed 32-bit products into a saturating ACC_W-bit
// accumulator. A group closes after N_TERMS products, or earlier on in_last.
// The result is then held until the consumer takes it. A new group can start
// in the same cycle the previous result is released.
module product_accumulator #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_count,
    output logic             out_ovf
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [8:0]       N_TERMS_9 = 9'(N_TERMS);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic             release_grp;
    logic [ACC_W-1:0] base_acc;
    logic [7:0]       base_count;
    logic             base_ovf;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W:0]   sum_ext;
    logic             add_ovf;
    logic [ACC_W-1:0] sum_sat;
    logic             closes;

    // Handshake and saturating adder. When a held result is released in the
    // same cycle as an accept, the add starts from an empty group so the new
    // group begins without a bubble.
    always_comb begin
        in_ready    = (state_q == ACCUM) || out_ready;
        accept      = in_valid && in_ready;
        release_grp = (state_q == HOLD) && out_ready;

        base_acc   = release_grp ? '0 : acc_q;
        base_count = release_grp ? 8'd0 : count_q;
        base_ovf   = release_grp ? 1'b0 : ovf_q;

        prod_ext = {{(ACC_W-32){in_prod[31]}}, in_prod};
        sum_ext  = {base_acc[ACC_W-1], base_acc} + {prod_ext[ACC_W-1], prod_ext};
        add_ovf  = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
        sum_sat  = add_ovf ? (sum_ext[ACC_W] ? SAT_MIN : SAT_MAX)
                           : sum_ext[ACC_W-1:0];
        closes   = (({1'b0, base_count} + 9'd1) == N_TERMS_9) || in_last;
    end

    // Next-state logic: release clears the group, an accept adds to it and
    // may close it.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (release_grp) begin
            state_d = ACCUM;
            acc_d   = '0;
            count_d = 8'd0;
            ovf_d   = 1'b0;
        end

        if (accept) begin
            acc_d   = sum_sat;
            count_d = base_count + 8'd1;
            ovf_d   = base_ovf | add_ovf;
            if (closes) begin
                state_d = HOLD;
            end
        end

        out_valid_d = (state_d == HOLD);
    end

    // State and group registers; reset discards any partial or held group.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            count_q     <= 8'd0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;
    assign out_count = count_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Testbench for product_accumulator.
// Instance A (N_TERMS=4, ACC_W=33) gets directed and random traffic and is
// checked by a scoreboard. Instance B (N_TERMS=1, ACC_W=40) streams single-
// product groups back to back.
module tb_product_accumulator;

    localparam int N_A     = 4;
    localparam int ACC_W_A = 33;
    localparam int N_B     = 1;
    localparam int ACC_W_B = 40;

    localparam longint MAX_A = (longint'(1) <<< (ACC_W_A-1)) - 1;
    localparam longint MIN_A = -MAX_A - 1;

    typedef struct {
        longint sum;
        int     cnt;
        bit     ovf;
    } exp_t;

    logic clk;
    int   checks = 0;
    int   errors = 0;

    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_prod;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W_A-1:0] out_sum;
    logic [7:0]         out_count;
    logic               out_ovf;

    logic               rst_b;
    logic               b_in_valid;
    logic               b_in_ready;
    logic [31:0]        b_in_prod;
    logic               b_in_last;
    logic               b_out_valid;
    logic               b_out_ready;
    logic [ACC_W_B-1:0] b_out_sum;
    logic [7:0]         b_out_count;
    logic               b_out_ovf;

    exp_t   exp_q[$];
    longint b_q[$];
    bit     m_held = 0;
    longint m_sum  = 0;
    int     m_cnt  = 0;
    bit     m_ovf  = 0;
    bit     b_en   = 0;
    bit     done_b = 0;

    product_accumulator #(.N_TERMS(N_A), .ACC_W(ACC_W_A)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    product_accumulator #(.N_TERMS(N_B), .ACC_W(ACC_W_B)) dut_b (
        .clk       (clk),
        .rst       (rst_b),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_prod   (b_in_prod),
        .in_last   (b_in_last),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_sum   (b_out_sum),
        .out_count (b_out_count),
        .out_ovf   (b_out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs on instance A, then update the reference model at the edge.
    task automatic applyStimulus(input bit v, input logic [31:0] p, input bit last, input bit ordy);
        bit rel;
        bit acc;
        in_valid  = v;
        in_prod   = p;
        in_last   = last;
        out_ready = ordy;
        rel = m_held && ordy;
        acc = v && (!m_held || ordy);
        @(posedge clk);
        if (rel) m_held = 0;
        if (acc) begin
            m_sum = m_sum + longint'($signed(p));
            if (m_sum > MAX_A) begin
                m_sum = MAX_A;
                m_ovf = 1;
            end else if (m_sum < MIN_A) begin
                m_sum = MIN_A;
                m_ovf = 1;
            end
            m_cnt++;
            if (m_cnt == N_A || last) begin
                exp_q.push_back('{m_sum, m_cnt, m_ovf});
                m_held = 1;
                m_sum  = 0;
                m_cnt  = 0;
                m_ovf  = 0;
            end
        end
        #2;
    endtask

    task automatic doReset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        m_held = 0;
        m_sum  = 0;
        m_cnt  = 0;
        m_ovf  = 0;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_sum", longint'(out_sum), 0);
        checkOutput("rst_out_count", out_count, 0);
        checkOutput("rst_out_ovf", out_ovf, 0);
        rst = 1'b0;
    endtask

    // Scoreboard monitor for instance A: handshake signals against the model,
    // and the held result against the front of the expected queue.
    always @(posedge clk) begin
        #4;
        if (!rst) begin
            checkOutput("in_ready", in_ready, (!m_held || out_ready) ? 1 : 0);
            checkOutput("out_valid", out_valid, m_held ? 1 : 0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_result", 1, 0);
                end else begin
                    checkOutput("out_sum", longint'($signed(out_sum)), exp_q[0].sum);
                    checkOutput("out_count", out_count, exp_q[0].cnt);
                    checkOutput("out_ovf", out_ovf, exp_q[0].ovf);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Monitor for instance B: every accepted product appears as its own result the next cycle.
    always @(posedge clk) begin
        #4;
        if (b_en) begin
            checkOutput("b_in_ready", b_in_ready, 1);
            checkOutput("b_out_valid", b_out_valid, (b_q.size() != 0) ? 1 : 0);
            if (b_out_valid && b_q.size() != 0) begin
                checkOutput("b_out_sum", longint'($signed(b_out_sum)), b_q[0]);
                checkOutput("b_out_count", b_out_count, 1);
                checkOutput("b_out_ovf", b_out_ovf, 0);
                void'(b_q.pop_front());
            end
        end
    end

    // Instance B stimulus: continuous valid with the consumer always ready.
    initial begin
        rst_b       = 1'b1;
        b_in_valid  = 1'b0;
        b_in_prod   = '0;
        b_in_last   = 1'b0;
        b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_b = 1'b0;
        b_en  = 1;
        for (int i = 0; i < 60; i++) begin
            b_in_prod  = $urandom;
            b_in_valid = 1'b1;
            @(posedge clk);
            b_q.push_back(longint'($signed(b_in_prod)));
            #2;
        end
        b_in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        b_en   = 0;
        done_b = 1;
    end

    // Instance A: directed scenarios followed by random traffic.
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #2;
        doReset();

        // Four-product group with mixed signs.
        applyStimulus(1, 32'd100, 0, 1);
        applyStimulus(1, -32'sd30, 0, 1);
        applyStimulus(1, 32'd7, 0, 1);
        applyStimulus(1, 32'h0000FFFF, 0, 1);
        applyStimulus(0, 32'd0, 0, 1);

        // Early close with in_last.
        applyStimulus(1, 32'd5, 0, 1);
        applyStimulus(1, -32'sd9, 1, 1);
        applyStimulus(0, 32'd0, 0, 1);

        // Positive saturation, then a clean group.
        repeat (4) applyStimulus(1, 32'h7FFFFFFF, 0, 1);
        applyStimulus(1, 32'd2, 1, 1);
        applyStimulus(0, 32'd0, 0, 1);

        // Negative saturation.
        repeat (4) applyStimulus(1, 32'h80000000, 0, 1);
        applyStimulus(0, 32'd0, 0, 1);

        // Stall with pending input, then release and accept in the same cycle.
        applyStimulus(1, 32'd1, 0, 0);
        applyStimulus(1, 32'd2, 0, 0);
        applyStimulus(1, 32'd3, 0, 0);
        applyStimulus(1, 32'd4, 0, 0);
        repeat (5) applyStimulus(1, $urandom, 0, 0);
        applyStimulus(1, 32'd3, 1, 1);
        applyStimulus(0, 32'd0, 0, 1);

        // Abort a partial group with reset.
        applyStimulus(1, 32'd10, 0, 1);
        applyStimulus(1, 32'd20, 0, 1);
        doReset();
        repeat (4) applyStimulus(1, 32'd1, 0, 1);
        applyStimulus(0, 32'd0, 0, 1);

        // Random traffic with a bias toward extreme products.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] p;
            case ($urandom % 4)
                0:       p = 32'h7FFFFFFF;
                1:       p = 32'h80000000;
                default: p = $urandom;
            endcase
            applyStimulus(($urandom % 4) != 0, p, ($urandom % 5) == 0, ($urandom % 3) != 0);
        end

        // Drain and confirm every expected result was presented.
        repeat (4) applyStimulus(0, 32'd0, 0, 1);
        checkOutput("drain_queue_empty", exp_q.size(), 0);

        wait (done_b);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter N_TERMS, default 4, meaning products per group; legal range 1..255.
REQ-002 SHALL have parameter ACC_W, default 40, meaning accumulator width; legal range 33..64.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  in_prod is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts in_prod this cycle.
REQ-007 SHALL have port in_prod  input  32  signed two's-complement product from the upstream 16x16 Booth multiplier.
REQ-008 SHALL have port in_last  input  1  qualified by in_valid; closes the group early.
REQ-009 SHALL have port out_valid  output  1  group result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port out_sum  output  ACC_W  signed group sum, saturated.
REQ-012 SHALL have port out_count  output  8  number of products in the group.
REQ-013 SHALL have port out_ovf  output  1  saturation occurred in the group (sticky per group).

Function
REQ-014 SHALL implement the FSM states ACCUM (collecting) and HOLD (result presented).
REQ-015 SHALL define an accept as in_valid && in_ready on a rising clk edge.
REQ-016 SHALL drive in_ready = 1 in ACCUM, and in_ready = out_ready in HOLD.
REQ-017 SHALL, on an accept in ACCUM, set acc <= sat(acc + sext(in_prod)) and count <= count + 1.
REQ-018 SHALL transition ACCUM->HOLD on an accept where count+1 == N_TERMS or in_last == 1.
REQ-019 SHALL assert out_valid the cycle after the closing accept (latency 1), with out_sum = acc and out_count = count.
REQ-020 SHALL hold out_sum/out_count/out_ovf stable while out_valid=1 && out_ready=0, and keep in_ready=0 during that stall.
REQ-021 SHALL, in HOLD with out_ready=1 and no accept, go to ACCUM with acc=0, count=0, ovf=0, and out_valid=0 the next cycle.
REQ-022 SHALL, in HOLD with out_ready=1 and an accept in the same cycle, start the new group with acc=sext(in_prod), count=1, ovf=0 (no bubble).
REQ-023 SHALL, in that case (REQ-022), go directly back to HOLD if that accept also closes the group (N_TERMS=1 or in_last=1).
REQ-024 SHALL saturate on signed overflow of the ACC_W-bit add: positive overflow -> 2^(ACC_W-1)-1, negative overflow -> -2^(ACC_W-1).
REQ-025 SHALL set ovf=1 on any saturation, and keep it set until the group is released.
REQ-026 SHALL continue accumulating from the saturated value after saturation; it shall not wrap.
REQ-027 SHALL sign-extend in_prod from bit 31; zero-extension is forbidden.
REQ-028 SHALL ignore in_prod and in_last when in_valid=0.
REQ-029 SHALL make out_sum, out_count and out_ovf don't-care while out_valid=0, but drive them from internal registers (no X).

Reset
REQ-030 SHALL, on rst=1 at a clk edge, set state=ACCUM, acc=0, count=0, ovf=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
REQ-031 SHALL give rst priority over any accept or release in the same cycle.
REQ-032 SHALL discard a partial group or a held result on rst with no output.
REQ-033 SHALL drive in_ready=1 in the first cycle after rst deasserts.

Verification
REQ-034 SHALL pass this scenario: N_TERMS=4, products 100, -30, 7, 0x0000FFFF with out_ready=1 -> out_valid one cycle after the 4th accept, out_sum=65612, out_count=4, out_ovf=0.
REQ-035 SHALL pass this scenario: in_last=1 on the 2nd product (5, -9) -> out_sum=-4 (all ones above bit 2), out_count=2.
REQ-036 SHALL pass this scenario: ACC_W=33, four products of 0x7FFFFFFF -> out_sum=0xFFFFFFFF (33-bit max), out_ovf=1; the next group starts with out_ovf=0.
REQ-037 SHALL pass this scenario: out_ready=0 for 5 cycles while out_valid=1 and in_valid=1 -> in_ready=0, outputs stable; then out_ready=1 with in_prod=3 -> next group acc=3, count=1, no idle cycle.
REQ-038 SHALL pass this scenario: rst=1 after 2 of 4 accepts, then 4 products of 1 -> out_sum=4, out_count=4; no result for the aborted group.
REQ-039 SHALL pass this scenario: N_TERMS=1 with continuous in_valid and out_ready=1 -> one result per cycle, each out_sum equal to the corresponding in_prod.
